fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter and drives the word address of the 512×32 synchronous-read instruction ROM.
- Tracks the ROM's one-cycle read latency and presents {instr, pc} to decode with a valid/ready handshake.
- A one-entry skid buffer prevents any fetched word from being lost when decode stalls.
- Redirects (branch/jump) flush in-flight fetches.

Parameters:
- ADDR_W, 9, ROM word-address width (512 words)
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- imem_addr  out  ADDR_W  ROM word address = pc_q[ADDR_W+1:2], combinational
- imem_dout  in  32  ROM data; registered by the ROM, valid one cycle after imem_addr
- redirect_valid  in  1  load a new PC, flush in-flight work
- redirect_pc  in  32  target byte address; bits [1:0] ignored (forced 0)
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts this cycle
- out_instr  out  32  instruction word; 0 when out_valid=0
- out_pc  out  32  byte address of out_instr
- perf_fetch_cnt  out  32  instructions handed to decode (optional feature)
- perf_stall_cnt  out  32  cycles with out_valid && !out_ready (optional feature)

Behaviour:
- Registers:
  - pc_q: next address to issue
  - rsp_valid_q, rsp_pc_q: a ROM read was issued last cycle
  - hold_valid_q, hold_instr_q, hold_pc_q: skid buffer
- Reset (async):
  - pc_q=RESET_PC; rsp_valid_q=0; hold_valid_q=0; counters 0
  - Outputs: out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC[ADDR_W+1:2]
- Output mux:
  - hold_valid_q → hold entry
  - else rsp_valid_q → {imem_dout, rsp_pc_q}
  - else invalid
- Per-clock priority:
  1. redirect_valid: pc_q=redirect_pc&~3; rsp_valid_q=0; hold_valid_q=0.
     - The ROM read issued this cycle is discarded.
     - A simultaneous out_valid&&out_ready handshake still counts as completed from decode's side. Squashing it is decode's responsibility.
  2. hold_valid_q && out_ready: hold_valid_q=0 and issue (see 4).
  3. hold_valid_q && !out_ready: no change; pc_q held; no issue.
  4. !hold_valid_q && rsp_valid_q && !out_ready: capture imem_dout, rsp_pc_q into hold; rsp_valid_q=0; pc_q held.
  5. Otherwise issue: rsp_valid_q=1; rsp_pc_q=pc_q; pc_q=pc_q+4.
- Latency: address issued in cycle n → out_valid in cycle n+1.
- Throughput: 1 instruction/cycle when out_ready stays high.
- First valid output appears the second clock after reset deasserts (first edge issues RESET_PC).
- Stall recovery: instruction order is preserved; no duplicates, no gaps.
- PC arithmetic: modulo 2^32. 32'hFFFF_FFFC+4 → 0.
- imem_addr aliasing: uses only pc_q[ADDR_W+1:2], so PC 0x800 aliases word 0. This is defined behaviour, not an error.
- ROM contents: valid from the first post-reset edge. The ROM reloads during reset, so a mid-operation reset discards all in-flight and held state.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments on each out_valid&&out_ready
  - perf_stall_cnt increments on each out_valid&&!out_ready
  - Both wrap at 2^32; both clear on reset; redirect does not clear them
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package fetch_pkg:
  - XLEN=32
  - PC_STEP=4
  - INSTR_NOP=32'h0
  - fetch_out_t struct {instr, pc}
- Sub-module fetch_skid_buf: 1-entry buffer with valid/ready on both sides, flush input.
  - fetch_unit keeps the PC register and the issue/priority logic.

Test Plan:
- Reset then out_ready=1, ROM[0..3]=A,B,C,D → out_valid rises cycle 2; outputs (A,0),(B,4),(C,8),(D,C) on consecutive cycles.
- out_ready low 3 cycles while (B,4) is presented → (B,4) held stable; imem_addr frozen at word 2; after release: B, C, D with no gaps or duplicates.
- redirect_valid with redirect_pc=0x0000_0043 while hold is full → next outputs (ROM[0x10],0x40),(ROM[0x11],0x44); held entry never reappears.
- Redirect to 0xFFFF_FFFC, out_ready=1 → out_pc 0xFFFF_FFFC then 0x0000_0000; imem_addr 511 then 0.
- Async reset asserted mid-stall → out_valid=0 immediately; restart yields (ROM[0],0).
- FETCH_PERF_CNT_EN defined: 10 accepts + 3 stall cycles → perf_fetch_cnt=10, perf_stall_cnt=3. Undefined: both read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] INSTR_NOP = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_out_t;

    // PC arithmetic wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer between the ROM response and decode; catches the
// in-flight word when decode stalls so nothing fetched is ever dropped.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    input  fetch_out_t in_data,
    input  logic       out_ready,
    output logic       out_valid,
    output fetch_out_t out_data
);

    logic       hold_valid_q;
    fetch_out_t hold_data_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            // NOTE: the payload is reset too; it is tiny and keeps sim free of X.
            hold_data_q  <= '0;
        end else if (flush) begin
            hold_valid_q <= 1'b0;
        end else if (hold_valid_q && out_ready) begin
            hold_valid_q <= 1'b0;
        end else if (!hold_valid_q && in_valid && !out_ready) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= in_data;
        end
    end

    // NOTE: defaults first so no path through always_comb can infer a latch.
    always_comb begin
        out_valid      = 1'b0;
        out_data.instr = INSTR_NOP;
        out_data.pc    = '0;
        if (hold_valid_q) begin
            out_valid = 1'b1;
            out_data  = hold_data_q;
        end else if (in_valid) begin
            out_valid = 1'b1;
            out_data  = in_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, ROM issue and redirect handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_dout,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
);

    logic [XLEN-1:0] pc_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic            issue;
    fetch_out_t      rsp_data;
    fetch_out_t      out_data;

    assign imem_addr = pc_q[ADDR_W+1:2];

    // A read is issued whenever the word on the output will leave (or none is
    // present). The skid entry and a pending response are never both valid.
    assign issue = !redirect_valid && (out_ready || !out_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
        end else begin
            rsp_valid_q <= issue;
            if (redirect_valid) begin
                pc_q <= redirect_pc & ~32'h3;
            end else if (issue) begin
                pc_q     <= pc_inc(pc_q);
                rsp_pc_q <= pc_q;
            end
        end
    end

    assign rsp_data = '{instr: imem_dout, pc: rsp_pc_q};

    fetch_skid_buf u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .in_valid  (rsp_valid_q),
        .in_data   (rsp_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    assign out_instr = out_data.instr;
    assign out_pc    = out_data.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (out_valid) begin
            if (out_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            else           stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// ready/redirect traffic against a stream-level reference model.
module tb_fetch_unit;

    localparam int          ADDR_W   = 9;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_dout;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [31:0]       perf_fetch_cnt;
    logic [31:0]       perf_stall_cnt;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction ROM.
    logic [31:0] rom [512];
    always @(posedge clk) imem_dout <= rom[imem_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: decode sees one in-order stream of PCs; the stream
    // shows a single bubble after reset or a redirect and is otherwise full.
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_acc;
    logic [31:0] m_stall;

    function automatic logic [31:0] rom_at(input logic [31:0] pc);
        logic [8:0] idx;
        idx = pc[10:2];
        return rom[idx];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = RESET_PC;
        m_acc   = '0;
        m_stall = '0;
    endtask

    task automatic check_outputs();
        logic [31:0] fetch_addr;
        // One word is always in flight or held, so the ROM runs one PC ahead.
        fetch_addr = m_valid ? m_pc + 32'd4 : m_pc;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("out_pc", out_pc, m_pc);
            check("out_instr", out_instr, rom_at(m_pc));
        end else begin
            check("idle_instr", out_instr, 32'h0);
        end
        check("imem_addr", {23'b0, imem_addr}, {23'b0, fetch_addr[10:2]});
        check("perf_fetch", perf_fetch_cnt, PERF_ON ? m_acc : 32'h0);
        check("perf_stall", perf_stall_cnt, PERF_ON ? m_stall : 32'h0);
    endtask

    // Called just after a falling edge: check, drive, advance one clock.
    task automatic cycle(input bit rdy, input bit rd, input logic [31:0] tgt);
        check_outputs();
        out_ready      = rdy;
        redirect_valid = rd;
        redirect_pc    = tgt;
        if (m_valid && rdy)  begin m_acc++; m_pc = m_pc + 32'd4; end
        if (m_valid && !rdy) m_stall++;
        if (rd) begin
            m_pc    = tgt & ~32'h3;
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_addr", {23'b0, imem_addr}, {23'b0, RESET_PC[10:2]});
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = $urandom;
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_valid", {31'b0, out_valid}, 32'h0);
        reset = 1'b0;

        // Straight-line fetch, then a 3-cycle stall while (B,4) is presented.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        check("stall_addr", {23'b0, imem_addr}, 32'd2);
        repeat (4) cycle(1, 0, 0);

        // Redirect with the skid entry full; bits [1:0] of the target dropped.
        repeat (2) cycle(0, 0, 0);
        cycle(0, 1, 32'h0000_0043);
        repeat (3) cycle(1, 0, 0);
        check("redir_pc", out_pc, 32'h0000_0048);

        // Wrap at the top of the address space.
        cycle(1, 1, 32'hFFFF_FFFC);
        check("wrap_addr_hi", {23'b0, imem_addr}, 32'd511);
        cycle(1, 0, 0);
        check("wrap_pc_hi", out_pc, 32'hFFFF_FFFC);
        check("wrap_addr_lo", {23'b0, imem_addr}, 32'd0);
        repeat (2) cycle(1, 0, 0);

        // Asynchronous reset mid-stall, then the counter scenario.
        repeat (2) cycle(0, 0, 0);
        async_reset();
        cycle(1, 0, 0);
        repeat (5) cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        repeat (5) cycle(1, 0, 0);
        check("perf_fetch_10", perf_fetch_cnt, PERF_ON ? 32'd10 : 32'd0);
        check("perf_stall_3", perf_stall_cnt, PERF_ON ? 32'd3 : 32'd0);

        // Random traffic with occasional redirects and resets.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            bit          rd;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            rd  = ($urandom_range(0, 19) == 0);
            if (n % 700 == 699) async_reset();
            cycle($urandom_range(0, 3) != 0, rd, tgt);
        end
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
